// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-to-memory bus plus the registered MEM/WB results.
//   ms_i_* : instruction presented by execute (ce, opcode, ALU result, rt data,
//            destination index, write enable) and the stall/flush controls.
//   ms_o_* : MEM/WB boundary registers consumed by writeback.
//   master : the execute/control side (drives ms_i_*, reads ms_o_*).
//   slave  : the memory stage itself.
interface memory_stage_if #(
  parameter int DWIDTH = 32
);
  logic              ms_i_ce;
  logic [5:0]        ms_i_opcode;
  logic [DWIDTH-1:0] ms_i_alu_value;
  logic [DWIDTH-1:0] ms_i_data_rt;
  logic [4:0]        ms_i_rd_addr;
  logic              ms_i_reg_write;
  logic              ms_i_stall;
  logic              ms_i_flush;

  logic              ms_o_ce;
  logic [DWIDTH-1:0] ms_o_alu_value;
  logic [DWIDTH-1:0] ms_o_load_data;
  logic              ms_o_mem_to_reg;
  logic [4:0]        ms_o_rd_addr;
  logic              ms_o_reg_write;
  logic              ms_o_misalign;

  modport master (
    output ms_i_ce, ms_i_opcode, ms_i_alu_value, ms_i_data_rt, ms_i_rd_addr,
           ms_i_reg_write, ms_i_stall, ms_i_flush,
    input  ms_o_ce, ms_o_alu_value, ms_o_load_data, ms_o_mem_to_reg,
           ms_o_rd_addr, ms_o_reg_write, ms_o_misalign
  );

  modport slave (
    input  ms_i_ce, ms_i_opcode, ms_i_alu_value, ms_i_data_rt, ms_i_rd_addr,
           ms_i_reg_write, ms_i_stall, ms_i_flush,
    output ms_o_ce, ms_o_alu_value, ms_o_load_data, ms_o_mem_to_reg,
           ms_o_rd_addr, ms_o_reg_write, ms_o_misalign
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with an internal word-organised data memory.
//   ms_i_clk : rising-edge clock
//   ms_i_rst : synchronous active-high reset (clears MEM/WB, memory untouched)
//   bus      : memory_stage_if.slave -- execute inputs, stall/flush, MEM/WB outputs
// Loads/stores LW/LB/LBU/SW/SB; everything else passes through. One-cycle
// latency, all outputs registered. Memory is split into one byte array per
// lane so SB touches a single lane without read-modify-write.
module memory_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256
) (
  input logic            ms_i_clk,
  input logic            ms_i_rst,
  memory_stage_if.slave  bus
);
  localparam int NUM_LANES = DWIDTH / 8;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef struct packed {
    logic              ce;
    logic [DWIDTH-1:0] alu;
    logic [DWIDTH-1:0] ld;
    logic              m2r;
    logic [4:0]        rd;
    logic              rw;
    logic              mis;
  } mwb_t;

  mwb_t mwb_d, mwb_q;

  logic                        is_lw, is_lb, is_lbu, is_sw, is_sb;
  logic                        is_load, is_store, misalign, accept, st_en;
  logic [AWIDTH-1:0]           widx;
  logic [1:0]                  byte_sel;
  logic [NUM_LANES-1:0][7:0]   rd_bytes;
  logic [7:0]                  rd_byte;
  logic [DWIDTH-1:0]           ld_val;

  assign widx     = bus.ms_i_alu_value[AWIDTH+1:2];
  assign byte_sel = bus.ms_i_alu_value[1:0];

  assign is_lw    = bus.ms_i_opcode == OP_LW;
  assign is_lb    = bus.ms_i_opcode == OP_LB;
  assign is_lbu   = bus.ms_i_opcode == OP_LBU;
  assign is_sw    = bus.ms_i_opcode == OP_SW;
  assign is_sb    = bus.ms_i_opcode == OP_SB;
  assign is_load  = is_lw | is_lb | is_lbu;
  assign is_store = is_sw | is_sb;
  // Only word accesses have an alignment requirement.
  assign misalign = (is_lw | is_sw) & (byte_sel != 2'b00);

  assign accept = ~ms_i_rst & ~bus.ms_i_stall & ~bus.ms_i_flush & bus.ms_i_ce;
  assign st_en  = accept & is_store & ~misalign;

  // Per-lane byte memories. Reads are asynchronous so the registered load
  // sees the array before any write on the same edge.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic       we;
    logic [7:0] wdata;

    assign we    = st_en & (is_sw | (byte_sel == 2'(l)));
    assign wdata = is_sw ? bus.ms_i_data_rt[8*l +: 8] : bus.ms_i_data_rt[7:0];

    always_ff @(posedge ms_i_clk) begin
      if (we) mem_q[widx] <= wdata;
    end

    assign rd_bytes[l] = mem_q[widx];
  end

  assign rd_byte = rd_bytes[byte_sel];

  always_comb begin
    ld_val = '0;
    if (is_lw)       ld_val = rd_bytes;
    else if (is_lb)  ld_val = {{(DWIDTH-8){rd_byte[7]}}, rd_byte};
    else if (is_lbu) ld_val = {{(DWIDTH-8){1'b0}}, rd_byte};
  end

  // Flush beats stall; a bubble (ce=0) clears only when not stalled.
  always_comb begin
    mwb_d = mwb_q;
    if (bus.ms_i_flush || (!bus.ms_i_stall && !bus.ms_i_ce)) begin
      mwb_d = '0;
    end else if (!bus.ms_i_stall) begin
      mwb_d.ce  = 1'b1;
      mwb_d.alu = bus.ms_i_alu_value;
      mwb_d.ld  = (is_load && !misalign) ? ld_val : '0;
      mwb_d.m2r = is_load & ~misalign;
      mwb_d.rd  = bus.ms_i_rd_addr;
      mwb_d.rw  = bus.ms_i_reg_write & ~is_store & ~misalign;
      mwb_d.mis = misalign;
    end
  end

  always_ff @(posedge ms_i_clk) begin
    if (ms_i_rst) mwb_q <= '0;
    else          mwb_q <= mwb_d;
  end

  assign bus.ms_o_ce         = mwb_q.ce;
  assign bus.ms_o_alu_value  = mwb_q.alu;
  assign bus.ms_o_load_data  = mwb_q.ld;
  assign bus.ms_o_mem_to_reg = mwb_q.m2r;
  assign bus.ms_o_rd_addr    = mwb_q.rd;
  assign bus.ms_o_reg_write  = mwb_q.rw;
  assign bus.ms_o_misalign   = mwb_q.mis;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vector table for memory_stage plus hand-written
// stall / flush / aliasing sequences. Each record is one clock: inputs driven
// before the edge, MEM/WB outputs compared 1 time unit after it.
module tb_memory_stage;
  localparam logic [5:0] LW = 6'h23, LB = 6'h20, LBU = 6'h24, SW = 6'h2B,
                         SB = 6'h28, ADD = 6'h00;

  typedef struct packed {
    logic        ce;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        m2r;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } out_t;

  typedef struct packed {
    logic        rst, stall, flush, ce;
    logic [5:0]  op;
    logic [31:0] alu, rt;
    logic [4:0]  rd;
    logic        rw;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  memory_stage_if #(.DWIDTH(32)) bus ();

  memory_stage #(.DWIDTH(32), .AWIDTH(8), .DEPTH(256)) dut (
    .ms_i_clk (clk),
    .ms_i_rst (rst),
    .bus      (bus.slave)
  );

  function automatic out_t o(input logic ce, input logic [31:0] alu, ld,
                             input logic m2r, input logic [4:0] rd,
                             input logic rw, mis);
    o = '{ce, alu, ld, m2r, rd, rw, mis};
  endfunction

  function automatic vec_t mk(input logic r, st, fl, ce, input logic [5:0] op,
                              input logic [31:0] alu, rt, input logic [4:0] rd,
                              input logic rw, input out_t exp);
    mk = '{r, st, fl, ce, op, alu, rt, rd, rw, exp};
  endfunction

  task automatic apply(input vec_t v, input string name);
    out_t act;
    rst                = v.rst;
    bus.ms_i_stall     = v.stall;
    bus.ms_i_flush     = v.flush;
    bus.ms_i_ce        = v.ce;
    bus.ms_i_opcode    = v.op;
    bus.ms_i_alu_value = v.alu;
    bus.ms_i_data_rt   = v.rt;
    bus.ms_i_rd_addr   = v.rd;
    bus.ms_i_reg_write = v.rw;
    @(posedge clk);
    #1;
    act = '{bus.ms_o_ce, bus.ms_o_alu_value, bus.ms_o_load_data,
            bus.ms_o_mem_to_reg, bus.ms_o_rd_addr, bus.ms_o_reg_write,
            bus.ms_o_misalign};
    checks++;
    if (act !== v.exp) begin
      failures++;
      $display("FAIL %s: got ce=%b alu=%h ld=%h m2r=%b rd=%0d rw=%b mis=%b, want ce=%b alu=%h ld=%h m2r=%b rd=%0d rw=%b mis=%b",
               name, act.ce, act.alu, act.ld, act.m2r, act.rd, act.rw, act.mis,
               v.exp.ce, v.exp.alu, v.exp.ld, v.exp.m2r, v.exp.rd, v.exp.rw, v.exp.mis);
    end
  endtask

  out_t Z;
  out_t add_o;
  vec_t tbl [18];

  initial begin
    Z = '0;
    rst = 1'b0;
    bus.ms_i_stall = 1'b0; bus.ms_i_flush = 1'b0; bus.ms_i_ce = 1'b0;
    bus.ms_i_opcode = '0; bus.ms_i_alu_value = '0; bus.ms_i_data_rt = '0;
    bus.ms_i_rd_addr = '0; bus.ms_i_reg_write = 1'b0;

    //               rst st fl ce op   alu       rt            rd rw  expected
    tbl[0]  = mk(0, 0, 0, 1, SW,  32'h10, 32'h11111111, 0, 1, o(1, 32'h10, 0, 0, 0, 0, 0));
    tbl[1]  = mk(1, 0, 0, 1, SW,  32'h10, 32'hDEADBEEF, 0, 1, Z);
    tbl[2]  = mk(1, 1, 1, 1, SW,  32'h10, 32'hDEADBEEF, 0, 1, Z);
    tbl[3]  = mk(0, 0, 0, 1, LW,  32'h10, 0,            3, 1, o(1, 32'h10, 32'h11111111, 1, 3, 1, 0));
    tbl[4]  = mk(0, 0, 0, 1, SW,  32'h10, 32'hDEADBEEF, 0, 1, o(1, 32'h10, 0, 0, 0, 0, 0));
    tbl[5]  = mk(0, 0, 0, 1, LW,  32'h10, 0,            5, 1, o(1, 32'h10, 32'hDEADBEEF, 1, 5, 1, 0));
    tbl[6]  = mk(0, 0, 0, 1, SB,  32'h11, 32'h12345680, 0, 0, o(1, 32'h11, 0, 0, 0, 0, 0));
    tbl[7]  = mk(0, 0, 0, 1, LW,  32'h10, 0,            1, 1, o(1, 32'h10, 32'hDEAD80EF, 1, 1, 1, 0));
    tbl[8]  = mk(0, 0, 0, 1, LB,  32'h11, 0,            2, 1, o(1, 32'h11, 32'hFFFFFF80, 1, 2, 1, 0));
    tbl[9]  = mk(0, 0, 0, 1, LBU, 32'h11, 0,            3, 1, o(1, 32'h11, 32'h00000080, 1, 3, 1, 0));
    tbl[10] = mk(0, 0, 0, 1, LB,  32'h13, 0,            8, 1, o(1, 32'h13, 32'hFFFFFFDE, 1, 8, 1, 0));
    tbl[11] = mk(0, 0, 0, 1, LW,  32'h13, 0,            4, 1, o(1, 32'h13, 0, 0, 4, 0, 1));
    tbl[12] = mk(0, 0, 0, 1, SW,  32'h12, 32'h1,        0, 1, o(1, 32'h12, 0, 0, 0, 0, 1));
    tbl[13] = mk(0, 0, 0, 1, LW,  32'h10, 0,            6, 1, o(1, 32'h10, 32'hDEAD80EF, 1, 6, 1, 0));
    tbl[14] = mk(0, 0, 0, 0, SW,  32'h10, 32'h0,        6, 1, Z);
    tbl[15] = mk(0, 0, 0, 1, LW,  32'h10, 0,            6, 1, o(1, 32'h10, 32'hDEAD80EF, 1, 6, 1, 0));
    tbl[16] = mk(0, 0, 0, 1, SW,  32'h20, 32'h0,        0, 0, o(1, 32'h20, 0, 0, 0, 0, 0));
    tbl[17] = mk(0, 0, 0, 1, SW,  32'h0,  32'h0,        0, 0, o(1, 32'h0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // ADD passes through, then stall holds it while a store is presented.
    add_o = o(1, 32'h1234, 0, 0, 7, 1, 0);
    apply(mk(0, 0, 0, 1, ADD, 32'h1234, 32'h0, 7, 1, add_o), "add");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 0, 1, SW, 32'h20, 32'hCAFEF00D, 9, 1, add_o), $sformatf("stall%0d", i));
    apply(mk(0, 0, 0, 1, LW, 32'h20, 0, 10, 1, o(1, 32'h20, 32'h0, 1, 10, 1, 0)), "stall_nowrite");
    apply(mk(0, 0, 0, 1, SW, 32'h20, 32'hCAFEF00D, 9, 1, o(1, 32'h20, 0, 0, 9, 0, 0)), "unstall_sw");
    apply(mk(0, 0, 0, 1, LW, 32'h20, 0, 11, 1, o(1, 32'h20, 32'hCAFEF00D, 1, 11, 1, 0)), "unstall_ld");

    // Flush wins over stall and blocks the write.
    apply(mk(0, 1, 1, 1, SW, 32'h20, 32'h99, 0, 0, Z), "flush_stall");
    apply(mk(0, 0, 0, 1, LW, 32'h20, 0, 12, 1, o(1, 32'h20, 32'hCAFEF00D, 1, 12, 1, 0)), "flush_nowrite");

    // 0x400 wraps to word 0.
    apply(mk(0, 0, 0, 1, SW, 32'h400, 32'h55, 0, 0, o(1, 32'h400, 0, 0, 0, 0, 0)), "alias_sw");
    apply(mk(0, 0, 0, 1, LW, 32'h0, 0, 13, 1, o(1, 32'h0, 32'h55, 1, 13, 1, 0)), "alias_ld");

    // Reset beats stall and a pending store.
    apply(mk(1, 1, 0, 1, SW, 32'h0, 32'hAA, 0, 0, Z), "rst_stall");
    apply(mk(0, 0, 0, 1, LW, 32'h0, 0, 14, 1, o(1, 32'h0, 32'h55, 1, 14, 1, 0)), "rst_nowrite");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's ALU result, opcode/funct and CE qualifier, plus the rt store data and writeback control carried alongside them.
- Performs data-memory loads and stores against an internal word-organised data memory.
- Registers everything into the MEM/WB boundary for the writeback stage.
- Supports pipeline stall and flush; flags misaligned word accesses.

Parameters:
- DWIDTH, 32, data word width; must equal `DWIDTH.
- AWIDTH, 8, word-address width of the internal memory.
- DEPTH, 256, number of memory words; must equal 2**AWIDTH.

Ports:
- ms_i_clk  input  1  rising-edge clock.
- ms_i_rst  input  1  synchronous, active-high reset.
- ms_i_ce  input  1  valid instruction from execute (execute CE output).
- ms_i_opcode  input  6  opcode from execute.
- ms_i_alu_value  input  DWIDTH  ALU result; byte address for loads/stores, else the result to write back.
- ms_i_data_rt  input  DWIDTH  store data (rt register value).
- ms_i_rd_addr  input  5  destination register index.
- ms_i_reg_write  input  1  instruction writes the register file.
- ms_i_stall  input  1  hold all MEM/WB outputs; no memory side effects.
- ms_i_flush  input  1  squash the instruction currently presented.
- ms_o_ce  output  1  MEM/WB valid.
- ms_o_alu_value  output  DWIDTH  registered ALU result.
- ms_o_load_data  output  DWIDTH  registered load result.
- ms_o_mem_to_reg  output  1  writeback selects load_data over alu_value.
- ms_o_rd_addr  output  5  registered destination index.
- ms_o_reg_write  output  1  registered write enable; forced 0 when ce=0 or misaligned.
- ms_o_misalign  output  1  registered misaligned-access flag.

Behaviour:
- Opcodes decoded: LW 6'h23, LB 6'h20, LBU 6'h24, SW 6'h2B, SB 6'h28. All other opcodes pass through with no memory access and mem_to_reg=0.
- Address handling:
  - Word index = ms_i_alu_value[AWIDTH+1:2]; byte lane = ms_i_alu_value[1:0], little-endian (lane 0 = bits 7:0).
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Accept condition: the input is accepted on a rising edge when ms_i_rst=0, ms_i_stall=0, ms_i_flush=0 and ms_i_ce=1.
- Latency: exactly 1 cycle. All outputs are registered; there are no combinational input-to-output paths.
- Loads read the memory array contents as of the accepting edge, i.e. before any write on that same edge. One op per cycle means no same-edge conflict.
- SW: writes the full word.
- SB: writes only the addressed lane with ms_i_data_rt[7:0].
- LW: returns the full word.
- LB: returns the byte, sign-extended to DWIDTH.
- LBU: returns the byte, zero-extended to DWIDTH.
- Misaligned access (LW/SW with alu_value[1:0]!=0):
  - No write.
  - load_data=0, reg_write=0, misalign=1.
  - ce=1 and rd_addr still registered.
- Non-load accepted instruction: load_data=0, mem_to_reg=0, reg_write=ms_i_reg_write.
- Store accepted instruction: reg_write=0 regardless of ms_i_reg_write.
- ms_i_ce=0 (no stall/flush): next outputs are all zero (bubble); no write.
- ms_i_stall=1: every output holds its value; no memory write; ms_i_* ignored.
- ms_i_flush=1: next outputs are all zero; no memory write. Flush has priority over stall.
- Reset:
  - Every output goes to 0 on the next edge.
  - Reset has priority over flush and stall; a store presented on the reset edge is not performed.
  - Memory contents are NOT reset; the bench must initialise memory before reading it.
- Consecutive store→load to the same address on back-to-back cycles: the load returns the newly stored data. The write lands on edge N; the load is accepted on edge N+1.

Test Plan:
- Reset asserted 2 cycles with ms_i_ce=1 and SW addr 0x10 data 0xDEADBEEF → all outputs 0; a later LW 0x10 does not return 0xDEADBEEF.
- SW addr 0x10 data 0xDEADBEEF, next cycle LW addr 0x10 rd=5 → one cycle later: ce=1, load_data=0xDEADBEEF, mem_to_reg=1, rd_addr=5, reg_write=1.
- After the above:
  - SB addr 0x11 data 0x80 → memory word 0xDEAD80EF.
  - LB 0x11 → load_data 0xFFFFFF80.
  - LBU 0x11 → load_data 0x00000080.
- LW addr 0x13 → misalign=1, reg_write=0, load_data=0. SW 0x12 data 0x1 → misalign=1 and the word at 0x10 is unchanged.
- Memory-access behaviour under control inputs:
  - ADD result 0x1234, reg_write=1, rd=7 → alu_value=0x1234, mem_to_reg=0, reg_write=1.
  - Assert stall 3 cycles with a new SW presented → outputs frozen at the ADD values; SW not written.
  - Deassert stall → SW written.
- SW presented with flush=1 and stall=1 simultaneously → next outputs all 0, memory unchanged. Address 0x400 with AWIDTH=8 aliases word 0: SW 0x400 data 0x55, then LW 0x0 → 0x55.
